// File: rtl/pipeline_pkg.sv
// Shared pipeline control definitions: hazard FSM encoding, register address width
// and the hard-wired zero register.
package pipeline_pkg;

  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MDU_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit up-counter with synchronous reset and enable.
// It sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Global pipeline enable plus per-register hold/flush/bubble controls.
// Covers load-use, taken-branch flush and multi-cycle MULT/DIV occupancy.
module hazard_stall_unit #(
  parameter int REG_AW     = pipeline_pkg::REG_AW,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] exe_load_dst,
  input  logic              exe_branch_taken,
  input  logic              exe_mdu_start,
  input  logic              exe_mdu_is_div,
  output logic              pipe_ena,
  output logic              pc_ena,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_exe_hold,
  output logic              id_exe_bubble,
  output logic              exe_mem_bubble,
  output logic              mdu_busy,
  output logic [31:0]       stall_cycles
);

  import pipeline_pkg::*;

  // The start cycle is the first of the N stall cycles, so the wait state runs N-1 more.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  hz_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;
  logic             mdu_stall;

  assign lu = exe_is_load && (exe_load_dst != REG_AW'(ZERO_REG)) &&
              ((id_uses_rs && (id_rs == exe_load_dst)) ||
               (id_uses_rt && (id_rt == exe_load_dst)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mdu_stall     = 1'b0;
    pipe_ena      = 1'b0;
    pc_ena        = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    if (ena) begin
      case (state)
        S_IDLE: state_nxt = S_RUN;
        S_RUN: begin
          pipe_ena = 1'b1;
          if (exe_mdu_start) begin
            mdu_stall = 1'b1;
            cnt_nxt   = exe_mdu_is_div ? DIV_LOAD : MUL_LOAD;
            state_nxt = S_MDU_WAIT;
          end else if (exe_branch_taken) begin
            // The ID instruction is wrong-path, so any load-use match is irrelevant.
            pc_ena        = 1'b1;
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
          end else if (lu) begin
            if_id_hold    = 1'b1;
            id_exe_bubble = 1'b1;
          end else begin
            pc_ena = 1'b1;
          end
        end
        S_MDU_WAIT: begin
          pipe_ena  = 1'b1;
          mdu_stall = 1'b1;
          if (cnt == '0) state_nxt = S_RUN;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    if (mdu_stall) if_id_hold = 1'b1;
  end

  assign id_exe_hold    = mdu_stall;
  assign exe_mem_bubble = mdu_stall;
  assign mdu_busy       = mdu_stall;

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ena && (state != S_IDLE) && !pc_ena),
    .count (stall_cycles)
  );

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Sits directly upstream of the pipeline stage-enable controller in the 5-stage MIPS core.
- Generates the global pipeline enable (`pipe_ena`) that the controller shifts into its per-stage enables.
- Generates the local hold, bubble and flush controls for the PC, IF/ID, ID/EXE and EXE/MEM registers.
- Resolves load-use hazards, branch-taken flushes and multi-cycle MULT/DIV occupancy, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_AW, 5, register address width
- MUL_CYCLES, 4, total EXE occupancy of MULT/MULTU in cycles (must be >= 2)
- DIV_CYCLES, 32, total EXE occupancy of DIV/DIVU in cycles (must be >= 2)
- CNT_W, 6, MDU down-counter width (must hold max(MUL_CYCLES, DIV_CYCLES) - 2)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ena  in  1  global run request; 0 freezes the pipeline
- id_rs  in  REG_AW  rs field of the instruction in ID
- id_rt  in  REG_AW  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- exe_is_load  in  1  EXE instruction is LW/LH/LB/LHU/LBU
- exe_load_dst  in  REG_AW  destination register of the load in EXE
- exe_branch_taken  in  1  EXE resolved a taken branch or jump
- exe_mdu_start  in  1  single-cycle pulse: a MULT/DIV entered EXE
- exe_mdu_is_div  in  1  qualifies exe_mdu_start; 1 = DIV, 0 = MULT
- pipe_ena  out  1  enable fed to the stage-enable controller
- pc_ena  out  1  PC update enable
- if_id_hold  out  1  IF/ID holds its contents
- if_id_flush  out  1  IF/ID loads a NOP
- id_exe_hold  out  1  ID/EXE holds its contents
- id_exe_bubble  out  1  ID/EXE loads a NOP
- exe_mem_bubble  out  1  EXE/MEM loads a NOP
- mdu_busy  out  1  high for every MULT/DIV occupancy cycle
- stall_cycles  out  32  saturating count of cycles with pc_ena = 0 while ena = 1

Behaviour:
- FSM states: S_IDLE, S_RUN, S_MDU_WAIT. Reset forces S_IDLE, cnt = 0, stall_cycles = 0.
- S_IDLE: every output is 0. Moves to S_RUN on the first edge with ena = 1 (one warm-up cycle after reset).
- When ena = 0 (any state), all enable, hold, flush and bubble outputs are 0. FSM, cnt and stall_cycles are frozen. pipe_ena = 0.
- pipe_ena = ena AND (state != S_IDLE).
- Load-use hazard (lu), evaluated combinationally: exe_is_load AND exe_load_dst != 0 AND ((id_uses_rs AND id_rs == exe_load_dst) OR (id_uses_rt AND id_rt == exe_load_dst)).
- Priority in S_RUN with ena = 1, highest first:
  1. exe_mdu_start: MDU stall this cycle: pc_ena = 0, if_id_hold = 1, id_exe_hold = 1, exe_mem_bubble = 1, mdu_busy = 1. Load cnt = N - 2, where N = DIV_CYCLES if exe_mdu_is_div else MUL_CYCLES. Go to S_MDU_WAIT. A simultaneous exe_branch_taken is ignored (illegal encoding).
  2. exe_branch_taken: pc_ena = 1, if_id_flush = 1, id_exe_bubble = 1. lu is ignored because the ID instruction is wrong-path.
  3. lu: pc_ena = 0, if_id_hold = 1, id_exe_bubble = 1. Exactly one cycle, purely combinational; the next cycle the load has moved to MEM.
  4. Otherwise pc_ena = 1 and all hold/flush/bubble outputs are 0.
- S_MDU_WAIT with ena = 1: same outputs as the MDU stall in item 1; all other inputs are ignored. If cnt == 0, go to S_RUN; else cnt decrements by 1.
- Total MDU stall is exactly N cycles, with mdu_busy high for N consecutive cycles.
- Mutual exclusion: hold and flush/bubble for the same register are never both 1.
- stall_cycles increments by 1 on each edge where ena = 1, state != S_IDLE and pc_ena = 0. It saturates at 0xFFFFFFFF and does not wrap.
- Reset mid-MDU-wait: next cycle is S_IDLE, all outputs 0, cnt = 0.

Decomposition:
- Shared package `pipeline_pkg`:
  - FSM state encoding (S_IDLE = 2'd0, S_RUN = 2'd1, S_MDU_WAIT = 2'd2)
  - REG_AW
  - the zero-register constant
- Sub-module `sat_counter32` (enable, synchronous reset, saturation) holds stall_cycles. All other logic is inline.

Test Plan:
- Reset, ena = 1 -> cycle 0 after reset all outputs 0 with state S_IDLE. Cycle 1: pipe_ena = 1, pc_ena = 1.
- Load-use: exe_is_load = 1, exe_load_dst = 8, id_rs = 8, id_uses_rs = 1 -> one cycle of pc_ena = 0, if_id_hold = 1, id_exe_bubble = 1; stall_cycles += 1. Repeat with exe_load_dst = 0 -> no stall.
- Branch plus load-use in the same cycle -> if_id_flush = 1, id_exe_bubble = 1, pc_ena = 1, if_id_hold = 0.
- exe_mdu_start with is_div = 0 (MUL_CYCLES = 4) -> mdu_busy high exactly 4 cycles, pc_ena = 0 for those 4, stall_cycles = 4, back to RUN. Same with is_div = 1 -> 32 cycles.
- DIV in progress with ena dropped for 5 cycles mid-wait -> outputs 0 and cnt frozen; after ena returns, remaining stall cycles complete for a total of 32 busy cycles.
- Reset asserted during S_MDU_WAIT -> next cycle all outputs 0, mdu_busy = 0, stall_cycles = 0. Saturation check: preload near max via long stall -> holds 0xFFFFFFFF.
